// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port shared-RAM arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   localparam int PORT_I = 0;
   localparam int PORT_D = 1;

   localparam int RAM_LAT_MIN = 1;
   localparam int RAM_LAT_MAX = 7;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester winner select. With MEM_ARB_RR_EN the port not served last wins a tie;
// otherwise the instruction port always wins and no pointer state exists.
module arb_rr2
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance,
`endif
   input  logic [1:0] req,
   output logic [1:0] win
);

`ifdef MEM_ARB_RR_EN
   logic last_d;

   always_comb begin
      win = 2'b00;
      if (req[PORT_I] && (!req[PORT_D] || last_d))
         win[PORT_I] = 1'b1;
      else if (req[PORT_D])
         win[PORT_D] = 1'b1;
   end

   // Reset leaves the pointer at D so the first tie goes to I.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_d <= 1'b1;
      else if (advance && (|req))
         last_d <= win[PORT_D];
   end
`else
   always_comb begin
      win = 2'b00;
      if (req[PORT_I])
         win[PORT_I] = 1'b1;
      else if (req[PORT_D])
         win[PORT_D] = 1'b1;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache accesses onto one shared RAM, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-break; default build is fixed priority (I wins).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; a request is granted and latched at the edge
//   ST_ISSUE | single cycle with the RAM port driven for the owner
//   ST_WAIT  | counting down the remaining RAM read latency
//   ST_DONE  | owner's completion pulse; read data captured at the edge
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int   RAM_LAT = 2,
   parameter logic D_BASE  = 1'b1
)
(
   input  logic        g_clk,
   input  logic        g_clr,
   input  logic        i_req,
   input  logic [7:0]  i_addr,
   output logic [15:0] i_rdata,
   output logic        i_odv,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [7:0]  d_addr,
   input  logic [7:0]  d_wdata,
   output logic [7:0]  d_rdata,
   output logic        d_odv,
   output logic        ram_en,
   output logic        ram_we,
   output logic [8:0]  ram_addr,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   output logic [1:0]  gnt
);

   localparam logic [2:0] WAIT_LOAD = 3'(RAM_LAT - 1);

   arb_state_e state;
   logic [2:0] wait_cnt;
   logic       own_d;
   logic       own_we;
   logic [1:0] win;

   arb_rr2 u_arb (
`ifdef MEM_ARB_RR_EN
      .clk     (g_clk),
      .rst_n   (g_clr),
      .advance (state == ST_IDLE),
`endif
      .req     ({d_req, i_req}),
      .win     (win)
   );

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         state     <= ST_IDLE;
         wait_cnt  <= 3'd0;
         own_d     <= 1'b0;
         own_we    <= 1'b0;
         gnt       <= 2'b00;
         i_rdata   <= 16'h0000;
         d_rdata   <= 8'h00;
         i_odv     <= 1'b0;
         d_odv     <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= 9'h000;
         ram_wdata <= 16'h0000;
      end else begin
         i_odv     <= 1'b0;
         d_odv     <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= 9'h000;
         ram_wdata <= 16'h0000;
         unique case (state)
            ST_IDLE: begin
               if (|win) begin
                  own_d     <= win[PORT_D];
                  own_we    <= win[PORT_D] & d_we;
                  gnt       <= win;
                  ram_en    <= 1'b1;
                  ram_we    <= win[PORT_D] & d_we;
                  ram_addr  <= win[PORT_D] ? {D_BASE, d_addr} : {~D_BASE, i_addr};
                  ram_wdata <= win[PORT_D] ? {8'h00, d_wdata} : 16'h0000;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (RAM_LAT > 1) begin
                  wait_cnt <= WAIT_LOAD;
                  state    <= ST_WAIT;
               end else begin
                  i_odv <= ~own_d;
                  d_odv <= own_d;
                  state <= ST_DONE;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 3'd1) begin
                  wait_cnt <= 3'd0;
                  i_odv    <= ~own_d;
                  d_odv    <= own_d;
                  state    <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_DONE: begin
               // Writes never touch the read-data registers.
               if (!own_we) begin
                  if (own_d)
                     d_rdata <= ram_rdata[7:0];
                  else
                     i_rdata <= ram_rdata;
               end
               gnt   <= 2'b00;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances (RAM_LAT 2, 1, 7) share one stimulus;
// the RAM_LAT=2 instance is also compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam logic D_BASE = 1'b1;
   localparam int   N_DUT  = 3;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
   endfunction

   function automatic logic [15:0] init_word(input logic [8:0] a);
      if (a == 9'h010) return 16'hBEEF;
      return {a[7:0] ^ 8'hC3, a[7:0] ^ {7'h00, a[8]} ^ 8'h5A};
   endfunction

   logic       g_clk = 1'b0;
   logic       g_clr = 1'b1;
   logic       i_req = 1'b0;
   logic [7:0] i_addr = 8'h00;
   logic       d_req = 1'b0;
   logic       d_we = 1'b0;
   logic [7:0] d_addr = 8'h00;
   logic [7:0] d_wdata = 8'h00;

   wire [15:0] i_rdata_w   [N_DUT];
   wire        i_odv_w     [N_DUT];
   wire [7:0]  d_rdata_w   [N_DUT];
   wire        d_odv_w     [N_DUT];
   wire        ram_en_w    [N_DUT];
   wire        ram_we_w    [N_DUT];
   wire [8:0]  ram_addr_w  [N_DUT];
   wire [15:0] ram_wdata_w [N_DUT];
   wire [1:0]  gnt_w       [N_DUT];

   int checks = 0;
   int failures = 0;

   // transaction-level reference for instance 0
   logic [15:0] mmem [512];
   bit          m_busy;
   int          m_issue, m_done;
   bit          m_own_d, m_we, m_last_d;
   logic [8:0]  m_addr;
   logic [15:0] m_i_rdata;
   logic [7:0]  m_d_rdata;

   always #5 g_clk = ~g_clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_inst
      localparam int LAT = lat_of(g);
      wire  [15:0] ram_rdata;
      logic [15:0] mem [512];
      int          rd_cnt = 0;
      logic [15:0] rd_val = 16'h0000;

      mem_arbiter #(.RAM_LAT(LAT), .D_BASE(D_BASE)) dut (
         .g_clk     (g_clk),
         .g_clr     (g_clr),
         .i_req     (i_req),
         .i_addr    (i_addr),
         .i_rdata   (i_rdata_w[g]),
         .i_odv     (i_odv_w[g]),
         .d_req     (d_req),
         .d_we      (d_we),
         .d_addr    (d_addr),
         .d_wdata   (d_wdata),
         .d_rdata   (d_rdata_w[g]),
         .d_odv     (d_odv_w[g]),
         .ram_en    (ram_en_w[g]),
         .ram_we    (ram_we_w[g]),
         .ram_addr  (ram_addr_w[g]),
         .ram_wdata (ram_wdata_w[g]),
         .ram_rdata (ram_rdata),
         .gnt       (gnt_w[g])
      );

      initial for (int a = 0; a < 512; a++) mem[a] = init_word(9'(a));

      // read data is valid only in the single cycle LAT cycles after ram_en is sampled
      always @(posedge g_clk) begin
         if (ram_en_w[g] && ram_we_w[g])
            mem[ram_addr_w[g]] = ram_wdata_w[g];
         if (ram_en_w[g] && !ram_we_w[g]) begin
            rd_cnt <= LAT;
            rd_val <= mem[ram_addr_w[g]];
         end else if (rd_cnt > 0) begin
            rd_cnt <= rd_cnt - 1;
         end
      end
      assign ram_rdata = (rd_cnt == 1) ? rd_val : 16'hDEAD;
   end

   function automatic logic [54:0] outs(input int k);
      return {i_rdata_w[k], d_rdata_w[k], i_odv_w[k], d_odv_w[k], ram_en_w[k],
              ram_we_w[k], ram_addr_w[k], ram_wdata_w[k], gnt_w[k]};
   endfunction

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic quiet(input int n);
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
      repeat (n) step();
   endtask

   task automatic pulse_reset();
      g_clr = 1'b0;
      step();
      g_clr = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #1 g_clr = 1'b0;
      #1;
      for (int k = 0; k < N_DUT; k++) begin
         checks++;
         if (outs(k) !== 55'd0) begin
            failures++;
            $display("FAIL reset_async[%0d]: outputs=%h expected 0", k, outs(k));
         end
      end
      step();
      step();
      checks++;
      if (outs(0) !== 55'd0) begin
         failures++;
         $display("FAIL reset_held: outputs=%h expected 0", outs(0));
      end
      g_clr = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      i_req  = 1'b1;
      i_addr = 8'h10;
      step();
      checks++;
      if ({ram_en_w[0], ram_we_w[0], ram_addr_w[0], gnt_w[0]} !== {1'b1, 1'b0, 9'h010, 2'b01}) begin
         failures++;
         $display("FAIL iread_issue: en=%b we=%b addr=%h gnt=%b expected en=1 we=0 addr=010 gnt=01",
                  ram_en_w[0], ram_we_w[0], ram_addr_w[0], gnt_w[0]);
      end
      i_req = 1'b0;
      step();
      checks++;
      if ({ram_en_w[0], ram_addr_w[0], gnt_w[0], i_odv_w[0]} !== {1'b0, 9'h000, 2'b01, 1'b0}) begin
         failures++;
         $display("FAIL iread_wait: en=%b addr=%h gnt=%b odv=%b expected 0 000 01 0",
                  ram_en_w[0], ram_addr_w[0], gnt_w[0], i_odv_w[0]);
      end
      step();
      checks++;
      if ({i_odv_w[0], d_odv_w[0]} !== 2'b10) begin
         failures++;
         $display("FAIL iread_odv: i_odv=%b d_odv=%b expected 1 0", i_odv_w[0], d_odv_w[0]);
      end
      step();
      checks++;
      if ({i_odv_w[0], i_rdata_w[0], gnt_w[0]} !== {1'b0, 16'hBEEF, 2'b00}) begin
         failures++;
         $display("FAIL iread_data: odv=%b rdata=%h gnt=%b expected 0 beef 00",
                  i_odv_w[0], i_rdata_w[0], gnt_w[0]);
      end
      quiet(12);
   endtask

   task automatic test_latency();
      int first [N_DUT];
      for (int k = 0; k < N_DUT; k++) first[k] = -1;
      i_req  = 1'b1;
      i_addr = 8'h33;
      step();
      for (int c = 1; c <= 12; c++) begin
         if (c == 1) i_req = 1'b0;
         for (int k = 0; k < N_DUT; k++)
            if (i_odv_w[k] && first[k] < 0) first[k] = c;
         step();
      end
      for (int k = 0; k < N_DUT; k++) begin
         checks++;
         if (first[k] != lat_of(k) + 1) begin
            failures++;
            $display("FAIL latency[lat=%0d]: odv cycle=%0d expected %0d", lat_of(k), first[k], lat_of(k) + 1);
         end
      end
      quiet(4);
   endtask

   task automatic test_write();
      logic [7:0] prev;
      prev    = d_rdata_w[0];
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 8'h20;
      d_wdata = 8'h5A;
      step();
      checks++;
      if ({ram_en_w[0], ram_we_w[0], ram_addr_w[0], ram_wdata_w[0], gnt_w[0]} !==
          {1'b1, 1'b1, 9'h120, 16'h005A, 2'b10}) begin
         failures++;
         $display("FAIL dwrite_issue: en=%b we=%b addr=%h wdata=%h gnt=%b expected 1 1 120 005a 10",
                  ram_en_w[0], ram_we_w[0], ram_addr_w[0], ram_wdata_w[0], gnt_w[0]);
      end
      d_req = 1'b0;
      d_we  = 1'b0;
      step();
      step();
      checks++;
      if ({i_odv_w[0], d_odv_w[0]} !== 2'b01) begin
         failures++;
         $display("FAIL dwrite_odv: i_odv=%b d_odv=%b expected 0 1", i_odv_w[0], d_odv_w[0]);
      end
      step();
      checks++;
      if (d_rdata_w[0] !== prev) begin
         failures++;
         $display("FAIL dwrite_rdata_hold: d_rdata=%h expected %h", d_rdata_w[0], prev);
      end
      mmem[9'h120] = 16'h005A;
      quiet(12);
      d_req = 1'b1;
      step();
      d_req = 1'b0;
      repeat (3) step();
      checks++;
      if (d_rdata_w[0] !== 8'h5A) begin
         failures++;
         $display("FAIL dread_back: d_rdata=%h expected 5a", d_rdata_w[0]);
      end
      quiet(12);
   endtask

   task automatic test_round_robin();
      logic [1:0] order [4];
      int         icyc  [4];
      int         cnt;
      logic [1:0] exp_g;
      pulse_reset();
      cnt    = 0;
      i_req  = 1'b1;
      d_req  = 1'b1;
      d_we   = 1'b0;
      i_addr = 8'h01;
      d_addr = 8'h02;
      for (int c = 0; c < 60 && cnt < 4; c++) begin
         if (ram_en_w[0]) begin
            order[cnt] = gnt_w[0];
            icyc[cnt]  = c;
            cnt++;
         end
         step();
      end
      quiet(12);
      checks++;
      if (cnt != 4) begin
         failures++;
         $display("FAIL rr_count: grants seen=%0d expected 4", cnt);
      end else begin
         for (int j = 0; j < 4; j++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            checks++;
            if (order[j] !== exp_g) begin
               failures++;
               $display("FAIL rr_order[%0d]: gnt=%b expected %b", j, order[j], exp_g);
            end
         end
         for (int j = 1; j < 4; j++) begin
            checks++;
            if (icyc[j] - icyc[j-1] != lat_of(0) + 2) begin
               failures++;
               $display("FAIL back_to_back[%0d]: spacing=%0d expected %0d", j, icyc[j] - icyc[j-1], lat_of(0) + 2);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 8'h44;
      step();
      d_req = 1'b0;
      step();
      checks++;
      if (gnt_w[0] !== 2'b10) begin
         failures++;
         $display("FAIL midreset_owner: gnt=%b expected 10", gnt_w[0]);
      end
      #2 g_clr = 1'b0;
      #1;
      checks++;
      if (outs(0) !== 55'd0) begin
         failures++;
         $display("FAIL midreset_outputs: outputs=%h expected 0", outs(0));
      end
      #2 g_clr = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (d_odv_w[0]) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL midreset_no_odv: d_odv seen=1 expected 0");
      end
      i_req  = 1'b1;
      i_addr = 8'h10;
      step();
      i_req = 1'b0;
      step();
      step();
      checks++;
      if (i_odv_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL midreset_recover_odv: i_odv=%b expected 1", i_odv_w[0]);
      end
      step();
      checks++;
      if (i_rdata_w[0] !== 16'hBEEF) begin
         failures++;
         $display("FAIL midreset_recover_data: i_rdata=%h expected beef", i_rdata_w[0]);
      end
      quiet(12);
   endtask

   task automatic test_random();
      bit         win_d, exp_i, exp_d, exp_en;
      int         grants;
      pulse_reset();
      m_busy    = 1'b0;
      m_last_d  = 1'b1;
      m_i_rdata = 16'h0000;
      m_d_rdata = 8'h00;
      m_issue   = -1;
      m_done    = -1;
      grants    = 0;
      for (int t = 0; t < 4000; t++) begin
         if (m_busy && t == m_done + 1) begin
            if (!m_we) begin
               if (m_own_d) m_d_rdata = mmem[m_addr][7:0];
               else         m_i_rdata = mmem[m_addr];
            end
            m_busy = 1'b0;
         end
         exp_i  = m_busy && t == m_done && !m_own_d;
         exp_d  = m_busy && t == m_done && m_own_d;
         exp_en = m_busy && t == m_issue;
         checks++;
         if ({i_odv_w[0], d_odv_w[0]} !== {exp_i, exp_d}) begin
            failures++;
            $display("FAIL rand_odv t=%0d: i_odv=%b d_odv=%b expected %b %b", t, i_odv_w[0], d_odv_w[0], exp_i, exp_d);
         end
         checks++;
         if ({i_rdata_w[0], d_rdata_w[0]} !== {m_i_rdata, m_d_rdata}) begin
            failures++;
            $display("FAIL rand_rdata t=%0d: i=%h d=%h expected %h %h", t, i_rdata_w[0], d_rdata_w[0], m_i_rdata, m_d_rdata);
         end
         checks++;
         if ({ram_en_w[0], ram_addr_w[0]} !== {exp_en, exp_en ? m_addr : 9'h000}) begin
            failures++;
            $display("FAIL rand_ram t=%0d: en=%b addr=%h expected %b %h", t, ram_en_w[0], ram_addr_w[0],
                     exp_en, exp_en ? m_addr : 9'h000);
         end
         for (int k = 0; k < N_DUT; k++) begin
            checks++;
            if (i_odv_w[k] && d_odv_w[k]) begin
               failures++;
               $display("FAIL odv_exclusive[lat=%0d] t=%0d: i_odv=1 d_odv=1 expected not both", lat_of(k), t);
            end
         end
         i_req   = ($urandom_range(0, 3) != 0);
         d_req   = ($urandom_range(0, 3) != 0);
         d_we    = $urandom_range(0, 1) == 1;
         i_addr  = 8'($urandom);
         d_addr  = 8'($urandom);
         d_wdata = 8'($urandom);
         if (!m_busy && (i_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
            win_d    = d_req && (!i_req || !m_last_d);
            m_last_d = win_d;
`else
            win_d = d_req && !i_req;
`endif
            m_own_d = win_d;
            m_we    = win_d && d_we;
            m_addr  = win_d ? {D_BASE, d_addr} : {~D_BASE, i_addr};
            m_issue = t + 1;
            m_done  = t + lat_of(0) + 1;
            if (m_we) mmem[m_addr] = {8'h00, d_wdata};
            m_busy = 1'b1;
            grants++;
         end
         step();
      end
      quiet(12);
      checks++;
      if (grants < 500) begin
         failures++;
         $display("FAIL rand_volume: grants=%0d expected at least 500", grants);
      end
   endtask

   initial begin
      for (int a = 0; a < 512; a++) mmem[a] = init_word(9'(a));
      test_reset();
      test_single_read();
      test_latency();
      test_write();
      test_round_robin();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 2, shared-RAM read latency in cycles from ram_en sample to valid ram_rdata, legal range 1..7.
REQ-002 Parameter D_BASE, default 1'b1, value driven on ram_addr[8] for data-side accesses (instruction side uses the complement).
REQ-003 g_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 g_clr  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  instruction-cache line-fill read request.
REQ-006 i_addr  input  8  instruction word address.
REQ-007 i_rdata  output  16  registered instruction read data.
REQ-008 i_odv  output  1  one-cycle pulse, instruction transaction complete.
REQ-009 d_req  input  1  data-cache request; d_we  input  1  1 = write.
REQ-010 d_addr  input  8; d_wdata  input  8  data-side address and write byte.
REQ-011 d_rdata  output  8  registered data read byte; d_odv  output  1  one-cycle completion pulse.
REQ-012 ram_en  output  1; ram_we  output  1; ram_addr  output  9; ram_wdata  output  16; ram_rdata  input  16  shared RAM port.
REQ-013 gnt  output  2  one-hot current owner, bit0 = I, bit1 = D, 2'b00 when idle.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight.
REQ-015 IDLE: if any req high, latch winner, its address, we and wdata at the edge, go ISSUE; else stay.
REQ-016 ISSUE (one cycle): ram_en = 1, ram_we = latched we (always 0 for I), ram_addr = {region bit, latched addr}, ram_wdata = {8'h00, latched wdata}; go WAIT if RAM_LAT > 1, else DONE.
REQ-017 WAIT: 3-bit counter loaded with RAM_LAT-1 on entry, decrements each cycle, go DONE at count 1.
REQ-018 DONE (one cycle): on read, capture ram_rdata into i_rdata (16 bits) or d_rdata (ram_rdata[7:0]); owner's odv = 1; go IDLE.
REQ-019 Latency: req first high in cycle 0 while IDLE -> odv high in cycle RAM_LAT+1; back-to-back requests separated by one IDLE cycle.
REQ-020 Request is captured at grant; a req deasserted mid-transaction still completes and still pulses odv.
REQ-021 A req still high in the cycle after its odv is treated as a new request.
REQ-022 Writes pulse d_odv at the same latency as reads and leave d_rdata unchanged.
REQ-023 Read data outputs hold their value until the next read completion for that same port.
REQ-024 ram_en, ram_we, ram_addr, ram_wdata are 0 outside ISSUE; gnt reflects owner in ISSUE/WAIT/DONE.
REQ-025 i_odv and d_odv are never high in the same cycle.

Reset
REQ-026 g_clr low asynchronously forces state IDLE, all outputs 0, i_rdata/d_rdata 0, counter 0, round-robin pointer "last = D".
REQ-027 Reset mid-transaction aborts it with no odv; after release the requester must re-present its request.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: on simultaneous requests in IDLE, grant the port not served last; pointer updates at each grant.
REQ-029 MEM_ARB_RR_EN undefined: fixed priority, I always beats D; pointer logic absent.

Structure
REQ-030 Package mem_arb_pkg holds the state enumeration, port-index constants (PORT_I = 0, PORT_D = 1) and the RAM_LAT range limits.
REQ-031 One sub-module arb_rr2: two-requester combinational winner select plus pointer register, instantiated once; it degenerates to fixed priority without MEM_ARB_RR_EN.

Verification
REQ-032 RAM_LAT = 2, i_req with i_addr = 8'h10, RAM model returns 16'hBEEF -> ram_addr = 9'h010 in cycle 1, i_odv in cycle 3, i_rdata = 16'hBEEF.
REQ-033 d_req, d_we = 1, d_addr = 8'h20, d_wdata = 8'h5A -> ram_we = 1, ram_addr = 9'h120, ram_wdata = 16'h005A, d_odv in cycle 3, d_rdata unchanged.
REQ-034 i_req and d_req held high together for 4 transactions -> with MEM_ARB_RR_EN the grant order is I, D, I, D; without it, I, I, I, I.
REQ-035 g_clr pulsed low during WAIT of a D read -> all outputs 0 immediately, no d_odv, next transaction after release completes normally.
REQ-036 RAM_LAT = 1 and RAM_LAT = 7 -> odv in cycle 2 and cycle 8 respectively; i_odv and d_odv never coincident over 1000 random requests.
